spi_master_sched: RTL and testbench

Round-robin SPI master controller that shares one SPI bus (SCLK, MOSI, MISO) between NREQ requesters, each owning one slave chip-select. It arbitrates pending requests, generates SCLK from the system clock, and sequences a full 8-bit LSB-first exchange matching the slave's timing: slave drives MISO on SCLK rise and samples MOSI on SCLK fall. It sits between the on-chip requesters and the bank of `Slave` instances.

---
 rtl/spi_master_sched_if.sv | 29 ++
 rtl/spi_master_sched.sv | 171 +++++++++++++++++
 tb/tb_spi_master_sched.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_sched_if.sv
// Bundle of requester-side handshake and shared SPI bus wires for spi_master_sched.
//   req/tx_data        : per-requester level request and transmit byte
//   grant/done/rx_data : one-hot grant, end-of-transfer pulse, received byte
//   busy               : controller not idle
//   SCLK/CS/MOSI/MISO  : shared SPI bus, active-low per-slave chip selects
interface spi_master_sched_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] tx_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [7:0]        rx_data;
    logic              busy;
    logic              SCLK;
    logic [NREQ-1:0]   CS;
    logic              MOSI;
    logic              MISO;

    modport master (
        input  req, tx_data, MISO,
        output grant, done, rx_data, busy, SCLK, CS, MOSI
    );

    modport slave (
        output req, tx_data, MISO,
        input  grant, done, rx_data, busy, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_master_sched.sv
// Round-robin SPI master shared by NREQ requesters, one chip select each.
// Runs one 8-bit LSB-first exchange per grant; slaves drive MISO on SCLK rise
// and sample MOSI on SCLK fall.
//   clk    : system clock
//   reset  : asynchronous, active-low
//   bus    : spi_master_sched_if.master (requester handshake + SPI pins)
module spi_master_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned CLK_DIV = 4
) (
    input logic             clk,
    input logic             reset,
    spi_master_sched_if.master bus
);
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {IDLE, SETUP, HI, LO, HOLD, DONE} state_t;

    state_t             state, state_d;
    logic [DIV_W-1:0]   div, div_d;
    logic [CNT_W-1:0]   bitcnt, bitcnt_d;
    logic [IDX_W-1:0]   rr, rr_d;
    logic [7:0]         tx_sh, tx_sh_d;
    logic [7:0]         rx_sh, rx_sh_d;
    logic [NREQ-1:0]    grant_r, grant_d;
    logic [NREQ-1:0]    done_r, done_d;
    logic [7:0]         rx_data_r, rx_data_d;
    logic               busy_r, busy_d;
    logic               sclk_r, sclk_d;
    logic [NREQ-1:0]    cs_r, cs_d;
    logic               mosi_r, mosi_d;

    logic               hit_hi, hit_lo, hit;
    logic [IDX_W-1:0]   win_hi, win_lo, win;
    logic [7:0]         tx_sel;
    logic               div_last;
    logic               active;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = NREQ'(1) << i;
    endfunction

    // Round-robin pick: lowest set index above rr, else lowest set index at/below rr.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        win_hi = '0;
        win_lo = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                if (IDX_W'(i) > rr) begin
                    hit_hi = 1'b1;
                    win_hi = IDX_W'(i);
                end else begin
                    hit_lo = 1'b1;
                    win_lo = IDX_W'(i);
                end
            end
        end
        hit = hit_hi | hit_lo;
        win = hit_hi ? win_hi : win_lo;
        tx_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IDX_W'(i) == win) tx_sel = bus.tx_data[8*i +: 8];
        end
    end

    assign div_last = (div == DIV_W'(CLK_DIV - 1));
    assign active   = (state == SETUP) || (state == HI) || (state == LO) || (state == HOLD);

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d   = state;
        div_d     = div;
        bitcnt_d  = bitcnt;
        rr_d      = rr;
        tx_sh_d   = tx_sh;
        rx_sh_d   = rx_sh;
        grant_d   = grant_r;
        rx_data_d = rx_data_r;

        if (active) div_d = div_last ? '0 : div + 1'b1;

        case (state)
            IDLE: begin
                grant_d = '0;
                if (hit) begin
                    state_d  = SETUP;
                    grant_d  = onehot(win);
                    rr_d     = win;
                    tx_sh_d  = tx_sel;
                    div_d    = '0;
                    bitcnt_d = '0;
                end
            end
            SETUP: if (div_last) state_d = HI;
            HI:    if (div_last) state_d = LO;
            LO: begin
                // First LO cycle is where SCLK visibly falls: capture MISO there.
                if (div == '0) begin
                    rx_sh_d  = {bus.MISO, rx_sh[7:1]};
                    bitcnt_d = bitcnt + 1'b1;
                end
                if (div_last) begin
                    if (bitcnt == CNT_W'(8)) begin
                        state_d = HOLD;
                    end else begin
                        state_d = HI;
                        tx_sh_d = {1'b0, tx_sh[7:1]};
                    end
                end
            end
            HOLD:  if (div_last) state_d = DONE;
            DONE: begin
                state_d   = IDLE;
                rx_data_d = rx_sh;
            end
            default: state_d = IDLE;
        endcase

        // Pin outputs follow the current state, so they trail the state edge by one clk.
        sclk_d = (state == HI);
        cs_d   = active ? ~onehot(rr) : '1;
        mosi_d = active ? tx_sh[0] : 1'b0;
        done_d = (state == DONE) ? onehot(rr) : '0;
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div       <= '0;
            bitcnt    <= '0;
            rr        <= IDX_W'(NREQ - 1);
            tx_sh     <= '0;
            rx_sh     <= '0;
            grant_r   <= '0;
            done_r    <= '0;
            rx_data_r <= '0;
            busy_r    <= 1'b0;
            sclk_r    <= 1'b0;
            cs_r      <= '1;
            mosi_r    <= 1'b0;
        end else begin
            state     <= state_d;
            div       <= div_d;
            bitcnt    <= bitcnt_d;
            rr        <= rr_d;
            tx_sh     <= tx_sh_d;
            rx_sh     <= rx_sh_d;
            grant_r   <= grant_d;
            done_r    <= done_d;
            rx_data_r <= rx_data_d;
            busy_r    <= busy_d;
            sclk_r    <= sclk_d;
            cs_r      <= cs_d;
            mosi_r    <= mosi_d;
        end
    end

    assign bus.grant   = grant_r;
    assign bus.done    = done_r;
    assign bus.rx_data = rx_data_r;
    assign bus.busy    = busy_r;
    assign bus.SCLK    = sclk_r;
    assign bus.CS      = cs_r;
    assign bus.MOSI    = mosi_r;
endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched (NREQ=2, CLK_DIV=4) with two behavioural
// SPI slaves: load on CS fall, drive MISO LSB-first on SCLK rise, sample MOSI on fall.
module tb_spi_master_sched;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned CLK_DIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    spi_master_sched_if #(.NREQ(NREQ)) bus();

    spi_master_sched #(.NREQ(NREQ), .CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave models and bus monitors, evaluated mid-cycle.
    logic [7:0] s_send [2];
    logic [7:0] s_sh   [2];
    logic [7:0] s_recv [2];
    int         s_loads [2] = '{0, 0};
    int         rises   = 0;
    int         two_low = 0;
    logic [1:0] cs_p    = 2'b11;
    logic       sclk_p  = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_p[i] && !bus.CS[i]) begin
                s_sh[i] = s_send[i];
                s_loads[i]++;
            end
            if (!bus.CS[i]) begin
                if (!sclk_p && bus.SCLK) begin
                    bus.MISO = s_sh[i][0];
                    s_sh[i]  = s_sh[i] >> 1;
                end
                if (sclk_p && !bus.SCLK) s_recv[i] = {bus.MOSI, s_recv[i][7:1]};
            end
        end
        if (bus.CS == 2'b11) bus.MISO = 1'b0;
        if (bus.CS == 2'b00) two_low++;
        if (!sclk_p && bus.SCLK) rises++;
        cs_p   = bus.CS;
        sclk_p = bus.SCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-transfer measurements, indexed by clk cycles after the grant edge.
    int         lat, cslow, nris, ndone, mosi_hi;
    logic [7:0] rx_at_done;
    logic       mosi_log [200];
    logic       sclk_log [200];

    // Pulse req[who] for one edge, then follow the transfer until done.
    task automatic xfer(input int who);
        int r0;
        bit seen;
        @(negedge clk);
        bus.req[who] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.grant[who]) begin
                seen = 1'b1;
                break;
            end
        end
        bus.req[who] = 1'b0;
        chk("grant_seen", 32'(seen), 32'd1);
        chk("busy_at_grant", 32'(bus.busy), 32'd1);
        r0 = rises; lat = 0; cslow = 0; ndone = 0; mosi_hi = 0;
        for (int n = 1; n < 200; n++) begin
            tick();
            mosi_log[n] = bus.MOSI;
            sclk_log[n] = bus.SCLK;
            if (!bus.CS[who]) begin
                cslow++;
                if (bus.MOSI) mosi_hi++;
            end
            if (bus.done[who]) begin
                lat = n;
                break;
            end
        end
        nris = rises - r0;
        rx_at_done = bus.rx_data;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.done[who]) ndone++;
        end
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200; n++) begin
            tick();
            if (|bus.done) break;
        end
    endtask

    initial begin
        int r0, gap, dn, loads0;
        logic [7:0] exp_rx [2];
        logic [7:0] exp_tx [2];
        bus.req     = '0;
        bus.tx_data = '0;
        s_send[0]   = 8'h00;
        s_send[1]   = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rx", 32'(bus.rx_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sclk", 32'(bus.SCLK), 32'd0);
        chk("rst_cs", 32'(bus.CS), 32'd3);
        chk("rst_mosi", 32'(bus.MOSI), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single transfer on requester 0
        s_send[0] = 8'h3C;
        bus.tx_data = 16'h00A5;
        xfer(0);
        chk("t1_done_lat", 32'(lat), 32'd73);
        chk("t1_cs_low", 32'(cslow), 32'd72);
        chk("t1_sclk_rises", 32'(nris), 32'd8);
        chk("t1_sclk_c4", 32'(sclk_log[4]), 32'd0);
        chk("t1_sclk_c5", 32'(sclk_log[5]), 32'd1);
        chk("t1_rx", 32'(rx_at_done), 32'h3C);
        chk("t1_slave_rx", 32'(s_recv[0]), 32'hA5);
        chk("t1_extra_done", 32'(ndone), 32'd0);
        chk("t1_busy_idle", 32'(bus.busy), 32'd0);
        chk("t1_cs_idle", 32'(bus.CS), 32'd3);
        chk("t1_rx_held", 32'(bus.rx_data), 32'h3C);

        // Bit order on requester 1
        s_send[1] = 8'h80;
        bus.tx_data = 16'h0100;
        xfer(1);
        chk("t2_done_lat", 32'(lat), 32'd73);
        chk("t2_rx", 32'(rx_at_done), 32'h80);
        chk("t2_slave_rx", 32'(s_recv[1]), 32'h01);
        chk("t2_mosi_c6", 32'(mosi_log[6]), 32'd1);
        chk("t2_mosi_c14", 32'(mosi_log[14]), 32'd0);
        chk("t2_mosi_hi_cycles", 32'(mosi_hi), 32'd12);

        // One-cycle req pulse still completes the full exchange
        s_send[1] = 8'hC3;
        bus.tx_data = 16'h5A00;
        xfer(1);
        chk("t3_done_lat", 32'(lat), 32'd73);
        chk("t3_rises", 32'(nris), 32'd8);
        chk("t3_rx", 32'(rx_at_done), 32'hC3);
        chk("t3_slave_rx", 32'(s_recv[1]), 32'h5A);
        chk("t3_extra_done", 32'(ndone), 32'd0);

        // Round robin with both requests held
        s_send[0] = 8'hA1; s_send[1] = 8'hB2;
        exp_rx[0] = 8'hA1; exp_rx[1] = 8'hB2;
        exp_tx[0] = 8'h11; exp_tx[1] = 8'h22;
        bus.tx_data = 16'h2211;
        @(negedge clk);
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_done();
            if (k == 3) bus.req = 2'b00;
            chk("rr_order", 32'(bus.done), 32'(2'b01 << (k % 2)));
            chk("rr_rx", 32'(bus.rx_data), 32'(exp_rx[k % 2]));
            chk("rr_slave_rx", 32'(s_recv[k % 2]), 32'(exp_tx[k % 2]));
        end
        repeat (4) tick();
        chk("rr_idle", 32'(bus.busy), 32'd0);

        // Reset after three SCLK rises
        s_send[0] = 8'h69;
        bus.tx_data = 16'h0096;
        @(negedge clk);
        bus.req = 2'b01;
        r0 = rises;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (rises - r0 >= 3) break;
        end
        bus.req = 2'b00;
        chk("t5_three_rises", 32'(rises - r0), 32'd3);
        chk("t5_cs_before", 32'(bus.CS), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_cs", 32'(bus.CS), 32'd3);
        chk("t5_rst_sclk", 32'(bus.SCLK), 32'd0);
        chk("t5_rst_mosi", 32'(bus.MOSI), 32'd0);
        chk("t5_rst_grant", 32'(bus.grant), 32'd0);
        chk("t5_rst_rx", 32'(bus.rx_data), 32'd0);
        dn = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (|bus.done) dn++;
        end
        chk("t5_no_done", 32'(dn), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.req = 2'b11;
        tick();
        bus.req = 2'b00;
        chk("t5_first_grant", 32'(bus.grant), 32'd1);
        wait_done();
        chk("t5_done", 32'(bus.done), 32'd1);
        chk("t5_rx", 32'(bus.rx_data), 32'h69);
        chk("t5_slave_rx", 32'(s_recv[0]), 32'h96);
        repeat (3) tick();

        // Back-to-back transfers with req[0] held
        s_send[0] = 8'h1E;
        bus.tx_data = 16'h0077;
        loads0 = s_loads[0];
        @(negedge clk);
        bus.req = 2'b01;
        wait_done();
        chk("t6_done1", 32'(bus.done), 32'd1);
        chk("t6_rx1", 32'(bus.rx_data), 32'h1E);
        s_send[0] = 8'hE1;
        gap = 0;
        for (int n = 0; n < 20; n++) begin
            if (!bus.CS[0]) break;
            gap++;
            tick();
        end
        bus.req = 2'b00;
        chk("t6_gap_ge2", 32'(gap >= 2), 32'd1);
        wait_done();
        chk("t6_done2", 32'(bus.done), 32'd1);
        chk("t6_rx2", 32'(bus.rx_data), 32'hE1);
        chk("t6_slave_rx", 32'(s_recv[0]), 32'h77);
        chk("t6_reloads", 32'(s_loads[0] - loads0), 32'd2);

        chk("never_two_cs_low", 32'(two_low), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
